// File: rtl/feeder_pkg.sv
// Shared constants and FSM state encoding for the character feeder.
package feeder_pkg;

  localparam logic [7:0] IDLE_CHAR_DEF = 8'h20;
  localparam logic [7:0] EQ_CHAR       = 8'h3D;
  localparam int         DEPTH_DEF     = 8;

  typedef enum logic {
    STREAM = 1'b0,
    GAP    = 1'b1
  } state_t;

endpackage

// File: rtl/char_feeder_if.sv
// Producer-side handshake, flush and registered character stream of the feeder.
interface char_feeder_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic [7:0] out_char;
  logic       out_valid;
  logic [7:0] expr_count;

  modport master (
    output in_data, in_valid, flush,
    input  in_ready, out_char, out_valid, expr_count
  );

  modport slave (
    input  in_data, in_valid, flush,
    output in_ready, out_char, out_valid, expr_count
  );

endinterface

// File: rtl/sync_fifo.sv
// Byte FIFO with wrap-around pointers and 0..DEPTH occupancy count; read data is the head entry.
// Synchronous active-low reset and flush both empty it; push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset && !flush && do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/char_feeder.sv
// Buffers producer bytes and emits one per cycle (1-cycle min latency), inserting one filler cycle after each '='.
// in_ready drops when the FIFO is full, during flush and during reset.
module char_feeder
  import feeder_pkg::*;
#(
  parameter int         DEPTH     = DEPTH_DEF,
  parameter logic [7:0] IDLE_CHAR = IDLE_CHAR_DEF
) (
  input  logic          clk,
  input  logic          reset,
  char_feeder_if.slave  bus
);

  state_t     state_q, state_d;
  logic [7:0] char_q, char_d;
  logic       vld_q, vld_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pop;
  logic       full;
  logic       empty;
  logic [7:0] rdata;

  assign bus.in_ready   = reset && !full && !bus.flush;
  assign bus.out_char   = char_q;
  assign bus.out_valid  = vld_q;
  assign bus.expr_count = cnt_q;

  sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (bus.flush),
    .push  (bus.in_valid && bus.in_ready),
    .pop   (pop),
    .wdata (bus.in_data),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    pop     = 1'b0;
    state_d = state_q;
    char_d  = IDLE_CHAR;
    vld_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      STREAM: begin
        if (!empty) begin
          pop    = 1'b1;
          char_d = rdata;
          vld_d  = 1'b1;
          // The cycle after '=' is left idle so the recogniser can settle its result.
          if (rdata == EQ_CHAR) begin
            state_d = GAP;
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          end
        end
      end
      GAP:     state_d = STREAM;
      default: state_d = STREAM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= STREAM;
      char_q  <= IDLE_CHAR;
      vld_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else if (bus.flush) begin
      state_q <= STREAM;
      char_q  <= IDLE_CHAR;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      char_q  <= char_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_char_feeder.sv
// Directed and random stimulus for char_feeder, checked every cycle against a queue-based reference model.
module tb_char_feeder;

  localparam int         DEPTH = 8;
  localparam logic [7:0] IDLE  = 8'h20;
  localparam logic [7:0] EQ    = 8'h3D;

  logic clk = 1'b0;
  logic reset;
  char_feeder_if bus();

  char_feeder #(.DEPTH(DEPTH), .IDLE_CHAR(IDLE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] q[$];
  bit         m_gap;
  logic [7:0] m_char;
  logic       m_vld;
  logic [7:0] m_cnt;
  bit         saw_stall;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready(input logic rst_v, input logic fl);
    return rst_v && !fl && (q.size() < DEPTH);
  endfunction

  // One clock: drive inputs, check in_ready, advance model, check registered outputs.
  task automatic step(input logic rst_v, input logic fl, input logic v, input logic [7:0] d);
    bit rdy;
    reset        = rst_v;
    bus.flush    = fl;
    bus.in_valid = v;
    bus.in_data  = d;
    #1;
    rdy = model_ready(rst_v, fl);
    check("in_ready", {7'd0, bus.in_ready}, {7'd0, rdy});
    @(posedge clk);
    if (!rst_v) begin
      q.delete(); m_gap = 0; m_char = IDLE; m_vld = 0; m_cnt = 0;
    end else if (fl) begin
      q.delete(); m_gap = 0; m_char = IDLE; m_vld = 0;
    end else begin
      if (!m_gap && q.size() > 0) begin
        m_char = q.pop_front();
        m_vld  = 1;
        m_gap  = (m_char == EQ);
        if (m_char == EQ && m_cnt != 8'hFF) m_cnt++;
      end else begin
        m_char = IDLE; m_vld = 0; m_gap = 0;
      end
      if (rdy && v) q.push_back(d);
    end
    #1;
    check("out_char", bus.out_char, m_char);
    check("out_valid", {7'd0, bus.out_valid}, {7'd0, m_vld});
    check("expr_count", bus.expr_count, m_cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 8'h00);
  endtask

  // Holds the byte on in_data until the model says it was accepted.
  task automatic push_hold(input logic [7:0] d);
    int tries = 0;
    bit done = 0;
    while (!done && tries < 64) begin
      done = model_ready(1, 0);
      if (!done) saw_stall = 1;
      step(1, 0, 1, d);
      tries++;
    end
    if (!done) check("push_timeout", 8'd0, 8'd1);
  endtask

  initial begin
    logic [7:0] seq [4];
    logic [7:0] pick [5];
    logic [7:0] cnt_before;
    reset = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    saw_stall = 0;

    step(0, 0, 1, "z");
    step(0, 0, 1, "z");
    check("reset_out_char", bus.out_char, IDLE);
    check("reset_count", bus.expr_count, 8'd0);

    seq = '{"a", "+", "p", "="};
    for (int i = 0; i < 4; i++) step(1, 0, 1, seq[i]);
    idle(3);
    check("eq_count_one", bus.expr_count, 8'd1);

    idle(4);
    check("idle_ready", {7'd0, bus.in_ready}, 8'd1);

    for (int i = 0; i < 20; i++) push_hold(EQ);
    push_hold("x");
    check("full_stall_seen", {7'd0, saw_stall}, 8'd1);
    idle(45);
    check("drained_valid", {7'd0, bus.out_valid}, 8'd0);

    step(1, 0, 1, "=");
    step(1, 0, 1, "a");
    step(1, 0, 1, "*");
    step(1, 0, 1, "0");
    cnt_before = bus.expr_count;
    step(1, 1, 1, "b");
    check("flush_valid", {7'd0, bus.out_valid}, 8'd0);
    check("flush_count", bus.expr_count, cnt_before);
    idle(3);

    for (int i = 0; i < 256; i++) push_hold(EQ);
    idle(20);
    check("sat_count", bus.expr_count, 8'hFF);

    pick = '{"=", "a", "1", "+", "="};
    for (int i = 0; i < 400; i++) begin
      logic [7:0] d;
      int r;
      r = $urandom_range(0, 99);
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pick[$urandom_range(0, 4)];
      step((r >= 2), (r >= 2 && r < 5), 1'($urandom), d);
    end

    for (int i = 0; i < 8; i++) step(1, 0, 1, EQ);
    step(0, 0, 1, "q");
    check("midreset_char", bus.out_char, IDLE);
    check("midreset_count", bus.expr_count, 8'd0);
    step(1, 0, 1, "a");
    step(1, 0, 1, "=");
    idle(3);
    check("restart_count", bus.expr_count, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
